// File: rtl/prog_load_ctrl.sv
// UART program loader for minisys: holds the core in reset and fills imem/dmem.
// Define LOAD_CHECKSUM_EN to require a trailing XOR checksum byte per segment.
module prog_load_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 2300000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              cpu_rst,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] HDR_IMEM = 8'hA5;
    localparam logic [7:0] HDR_DMEM = 8'h5A;
    localparam logic [7:0] HDR_RUN  = 8'h0F;
    localparam logic [7:0] HDR_HALT = 8'hF0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
`ifdef LOAD_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_RUN    = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    cnt_lo;
    logic [15:0]   n_left;
    logic [1:0]    byte_idx;
    logic [23:0]   shreg;
    logic [TW-1:0] tmo;
    logic          fin_pend;
`ifdef LOAD_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    logic        in_frame;
    logic        tmo_hit;
    logic        is_load;
    logic        is_run;
    logic        is_halt;
    logic        cnt_bad;
    logic        word_end;
    logic        last_word;
    logic [15:0] count_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (rx_valid && is_load)     state_nx = S_CNT_LO;
                else if (rx_valid && is_run) state_nx = S_RUN;
            end
            S_CNT_LO: if (rx_valid) state_nx = S_CNT_HI;
            S_CNT_HI: begin
                if (rx_valid) state_nx = cnt_bad ? S_IDLE : S_DATA;
            end
`ifdef LOAD_CHECKSUM_EN
            S_DATA:   if (last_word) state_nx = S_CHK;
            S_CHK:    if (rx_valid) state_nx = S_IDLE;
`else
            S_DATA:   if (last_word) state_nx = S_IDLE;
`endif
            S_RUN:    if (rx_valid && is_halt) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (tmo_hit) state_nx = S_IDLE;
    end

    always_comb begin
        unique case (state)
            S_CNT_LO, S_CNT_HI, S_DATA: in_frame = 1'b1;
`ifdef LOAD_CHECKSUM_EN
            S_CHK:                      in_frame = 1'b1;
`endif
            default:                    in_frame = 1'b0;
        endcase
        count_n   = {rx_data, cnt_lo};
        cnt_bad   = (count_n == 16'd0) ||
                    (32'(count_n) > (32'd1 << ADDR_W));
        is_load   = (rx_data == HDR_IMEM) || (rx_data == HDR_DMEM);
        is_run    = (rx_data == HDR_RUN);
        is_halt   = (rx_data == HDR_HALT);
        tmo_hit   = in_frame && !rx_valid &&
                    (tmo == TW'(TIMEOUT_CYC - 1));
        word_end  = (state == S_DATA) && rx_valid && (byte_idx == 2'd3);
        last_word = word_end && (n_left == 16'd1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_rst   <= 1'b1;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt_lo    <= '0;
            n_left    <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
            tmo       <= '0;
            fin_pend  <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we   <= 1'b0;
            done     <= fin_pend;
            fin_pend <= 1'b0;
            tmo      <= (in_frame && !rx_valid && !tmo_hit) ? tmo + 1'b1 : '0;
            // address advances after each strobe except the segment's last
            if (mem_we && n_left != 16'd0) mem_addr <= mem_addr + 1'b1;
            if (tmo_hit) begin
                err  <= 1'b1;
                busy <= 1'b0;
            end
            if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (is_load) begin
                            mem_sel  <= (rx_data == HDR_DMEM);
                            mem_addr <= '0;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            byte_idx <= '0;
`ifdef LOAD_CHECKSUM_EN
                            csum     <= '0;
`endif
                        end else if (is_run) begin
                            err     <= 1'b0;
                            cpu_rst <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    S_CNT_LO: cnt_lo <= rx_data;
                    S_CNT_HI: begin
                        if (cnt_bad) begin
                            err  <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            n_left <= count_n;
                        end
                    end
                    S_DATA: begin
                        shreg    <= {rx_data, shreg[23:8]};
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOAD_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        if (word_end) begin
                            mem_wdata <= {rx_data, shreg};
                            mem_we    <= 1'b1;
                            n_left    <= n_left - 16'd1;
`ifndef LOAD_CHECKSUM_EN
                            if (last_word) begin
                                busy     <= 1'b0;
                                fin_pend <= 1'b1;
                            end
`endif
                        end
                    end
`ifdef LOAD_CHECKSUM_EN
                    S_CHK: begin
                        busy <= 1'b0;
                        if (rx_data == csum) done <= 1'b1;
                        else                 err  <= 1'b1;
                    end
`endif
                    S_RUN: if (is_halt) cpu_rst <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: directed and random byte streams checked each cycle
// against a frame-level model of the loader.
module tb_prog_load_ctrl;

    localparam int AW = 14;
    localparam int T  = 40;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          cpu_rst;
    logic          mem_we;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    prog_load_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
        .clock(clock), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .cpu_rst(cpu_rst), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // expected outputs
    logic          e_cpu_rst, e_we, e_sel, e_busy, e_done, e_err;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;

    // frame model: 0 idle, 1 in frame, 2 awaiting checksum, 3 running
    int         m_mode, m_pos, m_n, m_words, m_idle;
    logic [7:0] m_lo, m_x;
    logic [7:0] m_wb [4];
    logic       m_dnext;

    logic [31:0] wlog_data [$];
    int          wlog_addr [$];
    logic        wlog_sel [$];

    always @(posedge clock or posedge reset) begin : model
        logic old_we;
        int   j;
        if (reset) begin
            e_cpu_rst = 1'b1; e_we = 1'b0; e_sel = 1'b0; e_busy = 1'b0;
            e_done = 1'b0; e_err = 1'b0; e_addr = '0; e_wdata = '0;
            m_mode = 0; m_pos = 0; m_n = 0; m_words = 0; m_idle = 0;
            m_lo = 8'h00; m_x = 8'h00; m_dnext = 1'b0;
        end else begin
            old_we  = e_we;
            e_we    = 1'b0;
            e_done  = m_dnext;
            m_dnext = 1'b0;
            if (old_we && m_words < m_n) e_addr = AW'(m_words);
            if (m_mode == 1 || m_mode == 2) begin
                if (rx_valid) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == T) begin
                        e_err = 1'b1; e_busy = 1'b0; m_mode = 0; m_idle = 0;
                    end
                end
            end
            if (rx_valid) begin
                case (m_mode)
                    0: begin
                        if (rx_data == 8'hA5 || rx_data == 8'h5A) begin
                            e_sel = (rx_data == 8'h5A); e_err = 1'b0;
                            e_addr = '0; e_busy = 1'b1; m_mode = 1;
                            m_pos = 0; m_words = 0; m_x = 8'h00;
                            m_idle = 0; m_n = 0;
                        end else if (rx_data == 8'h0F) begin
                            e_err = 1'b0; e_cpu_rst = 1'b0; m_mode = 3;
                        end else begin
                            e_err = 1'b1;
                        end
                    end
                    1: begin
                        if (m_pos == 0) m_lo = rx_data;
                        else if (m_pos == 1) begin
                            m_n = {16'd0, rx_data, m_lo};
                            if (m_n == 0 || m_n > (1 << AW)) begin
                                e_err = 1'b1; e_busy = 1'b0; m_mode = 0;
                            end
                        end else begin
                            j = m_pos - 2;
                            m_wb[j % 4] = rx_data;
                            m_x ^= rx_data;
                            if (j % 4 == 3) begin
                                e_wdata = {m_wb[3], m_wb[2], m_wb[1], m_wb[0]};
                                e_we = 1'b1;
                                wlog_data.push_back(e_wdata);
                                wlog_addr.push_back(m_words);
                                wlog_sel.push_back(e_sel);
                                m_words++;
                                if (m_words == m_n) begin
`ifdef LOAD_CHECKSUM_EN
                                    m_mode = 2;
`else
                                    m_mode = 0; e_busy = 1'b0; m_dnext = 1'b1;
`endif
                                end
                            end
                        end
                        m_pos++;
                    end
                    2: begin
                        e_busy = 1'b0; m_mode = 0;
                        if (rx_data == m_x) e_done = 1'b1;
                        else                e_err = 1'b1;
                    end
                    default: begin
                        if (rx_data == 8'hF0) begin
                            e_cpu_rst = 1'b1; m_mode = 0;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clock) begin
        checks++;
        if ({cpu_rst, mem_we, mem_sel, busy, done, err} !==
            {e_cpu_rst, e_we, e_sel, e_busy, e_done, e_err} ||
            mem_addr !== e_addr || mem_wdata !== e_wdata) begin
            failures++;
            $display("FAIL cycle t=%0t got rst=%b we=%b sel=%b busy=%b done=%b err=%b addr=%h data=%h want rst=%b we=%b sel=%b busy=%b done=%b err=%b addr=%h data=%h",
                     $time, cpu_rst, mem_we, mem_sel, busy, done, err,
                     mem_addr, mem_wdata, e_cpu_rst, e_we, e_sel, e_busy,
                     e_done, e_err, e_addr, e_wdata);
        end
    end

    task automatic lit(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = b;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        drive(1'b1, b);
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        wlog_data.delete(); wlog_addr.delete(); wlog_sel.delete();
    endtask

    initial begin
        #7;
        lit("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        lit("rst_busy", 32'(busy), 32'd0);
        lit("rst_err", 32'(err), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // two-word imem load
        clear_log();
        send(8'hA5, 1); send(8'h02, 1); send(8'h00, 1);
        send(8'h78, 1); send(8'h56, 0); send(8'h34, 2); send(8'h12, 1);
        send(8'hEF, 1); send(8'hBE, 1); send(8'hAD, 0); send(8'hDE, 1);
        #3;
        lit("t2_we", 32'(mem_we), 32'd1);
        lit("t2_wdata", mem_wdata, 32'hDEADBEEF);
        lit("t2_addr", 32'(mem_addr), 32'd1);
`ifdef LOAD_CHECKSUM_EN
        send(8'h2A, 0); #3;
`else
        drive(1'b0, 8'h00); #3;
`endif
        lit("t2_done", 32'(done), 32'd1);
        lit("t2_busy", 32'(busy), 32'd0);
        lit("t2_nwr", wlog_data.size(), 32'd2);
        if (wlog_data.size() == 2) begin
            lit("t2_w0", wlog_data[0], 32'h12345678);
            lit("t2_a0", wlog_addr[0], 32'd0);
            lit("t2_w1", wlog_data[1], 32'hDEADBEEF);
            lit("t2_a1", wlog_addr[1], 32'd1);
            lit("t2_sel", 32'(wlog_sel[0]), 32'd0);
        end

        // dmem load then run/halt
        clear_log();
        send(8'h5A, 2); send(8'h01, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 1); send(8'h33, 0); send(8'h44, 0);
`ifdef LOAD_CHECKSUM_EN
        send(8'h44, 1);
`endif
        send(8'h0F, 2); #3;
        lit("t3_run", 32'(cpu_rst), 32'd0);
        lit("t3_sel", 32'(mem_sel), 32'd1);
        lit("t3_nwr", wlog_data.size(), 32'd1);
        if (wlog_data.size() == 1)
            lit("t3_w0", wlog_data[0], 32'h44332211);
        send(8'h0F, 1); send(8'hA5, 1); #3;
        lit("t3_ign", 32'(cpu_rst), 32'd0);
        lit("t3_ign_busy", 32'(busy), 32'd0);
        send(8'hF0, 1); #3;
        lit("t3_halt", 32'(cpu_rst), 32'd1);

        // zero / oversize count and timeout
        send(8'hA5, 1); send(8'h00, 0); send(8'h00, 0); #3;
        lit("t4_zero_err", 32'(err), 32'd1);
        lit("t4_zero_busy", 32'(busy), 32'd0);
        send(8'hA5, 1); #3;
        lit("t4_hdr_clr", 32'(err), 32'd0);
        send(8'h01, 0); send(8'h00, 0); send(8'hAA, 1); send(8'hBB, 1);
        idle(T - 2); #3;
        lit("t4_pre_tmo", 32'(err), 32'd0);
        idle(3); #3;
        lit("t4_tmo_err", 32'(err), 32'd1);
        lit("t4_tmo_busy", 32'(busy), 32'd0);
        send(8'hA5, 2); #3;
        lit("t4_reclr", 32'(err), 32'd0);
        send(8'h01, 0); send(8'h40, 0); #3;
        lit("t4_big_err", 32'(err), 32'd1);
        send(8'h5A, 1); send(8'h00, 0); send(8'h40, 0); #3;
        lit("t4_max_ok", 32'(busy), 32'd1);
        idle(T + 2);

        // back-to-back bytes
        clear_log();
        send(8'hA5, 1); send(8'h02, 0); send(8'h00, 0);
        for (int k = 1; k <= 8; k++) send(8'(k), 0);
`ifdef LOAD_CHECKSUM_EN
        send(8'h08, 0);
`endif
        idle(2);
        lit("t5_nwr", wlog_data.size(), 32'd2);
        if (wlog_data.size() == 2) begin
            lit("t5_w0", wlog_data[0], 32'h04030201);
            lit("t5_w1", wlog_data[1], 32'h08070605);
        end

`ifdef LOAD_CHECKSUM_EN
        send(8'hA5, 1); send(8'h01, 0); send(8'h00, 0);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        send(8'h04, 1); #3;
        lit("t6_done", 32'(done), 32'd1);
        send(8'hA5, 1); send(8'h01, 0); send(8'h00, 0);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        send(8'h05, 1); #3;
        lit("t6_bad_err", 32'(err), 32'd1);
        lit("t6_bad_done", 32'(done), 32'd0);
`endif

        // reset while a word is being written
        send(8'hA5, 1); send(8'h02, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        #2 reset = 1'b1;
        #1;
        lit("t1_we", 32'(mem_we), 32'd0);
        lit("t1_cpu_rst", 32'(cpu_rst), 32'd1);
        lit("t1_busy", 32'(busy), 32'd0);
        lit("t1_wdata", mem_wdata, 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        idle(2);

        // random streams
        for (int it = 0; it < 70; it++) begin
            int kind;
            int n;
            int cut;
            logic [7:0] x;
            logic [7:0] b;
            kind = $urandom_range(0, 7);
            if (kind <= 5) begin
                n = $urandom_range(1, 4);
                x = 8'h00;
                cut = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
                send((kind % 2 == 1) ? 8'h5A : 8'hA5, $urandom_range(0, 3));
                send(8'(n), $urandom_range(0, 2));
                send(8'h00, $urandom_range(0, 2));
                for (int k = 0; k < 4 * n; k++) begin
                    if (k == cut) idle(T + 2);
                    b = 8'($urandom);
                    x ^= b;
                    send(b, $urandom_range(0, 2));
                end
`ifdef LOAD_CHECKSUM_EN
                send(($urandom_range(0, 3) == 0) ? ~x : x, $urandom_range(0, 2));
`endif
            end else if (kind == 6) begin
                send(8'($urandom), $urandom_range(0, 2));
            end else begin
                send(8'h0F, $urandom_range(0, 2));
                repeat (3) send(8'($urandom_range(0, 8'hEF)), $urandom_range(0, 2));
                send(8'hF0, $urandom_range(0, 2));
            end
        end
        idle(T + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
